// File: rtl/branch_seq_if.sv
// branch_seq_if: control-unit <-> branch sequencer signal bundle.
interface branch_seq_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [31:0]      IR;
    logic [31:0]      busContents;
    logic             Gra;
    logic             Rout;
    logic             CONin;
    logic             PCout;
    logic             Yin;
    logic             Cout;
    logic             ADD;
    logic             Zin;
    logic             Zlowout;
    logic             PCin;
    logic             CON;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] taken_cnt;
    logic [CNT_W-1:0] ntaken_cnt;
    modport master (
        output start, abort, IR, busContents,
        input  Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin, CON, busy, done,
        input  taken_cnt, ntaken_cnt
    );
    modport slave (
        input  start, abort, IR, busContents,
        output Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin, CON, busy, done,
        output taken_cnt, ntaken_cnt
    );
endinterface

// File: rtl/branch_seq.sv
// branch_seq: T3-T6 sequencer for brzr/brnz/brpl/brmi with CON latch and taken/not-taken counters.
module branch_seq #(
    parameter int EARLY_EXIT = 1,
    parameter int CNT_W      = 16
) (
    input logic         clock,
    input logic         clear,
    branch_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, T3, T4, T5, T6} state_t;
    localparam logic EE = (EARLY_EXIT != 0);
    state_t           r_state, w_next;
    logic             r_con;
    logic [CNT_W-1:0] r_taken, r_ntaken;
    logic [1:0]       w_code;
    logic             w_zero, w_cond, w_done, w_inc_t, w_inc_n;
    assign w_code = bus.IR[20:19];
    assign w_zero = (bus.busContents == 32'd0);
    always_comb begin
        w_cond = w_code == 2'b00 ? w_zero :
                 w_code == 2'b01 ? !w_zero :
                 w_code == 2'b10 ? (!bus.busContents[31] && !w_zero) : bus.busContents[31];
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.start ? T3 : IDLE;
            T3:      w_next = (EE && !w_cond) ? IDLE : T4;
            T4:      w_next = T5;
            T5:      w_next = T6;
            default: w_next = IDLE;
        endcase
        if (bus.abort) w_next = IDLE;
    end
    // Early exit decides on the live condition, since CON only updates at the end of T3
    assign w_done  = !bus.abort && (r_state == T6 || (r_state == T3 && EE && !w_cond));
    assign w_inc_t = w_done && r_state == T6 && r_con;
    assign w_inc_n = w_done && !w_inc_t;
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state  <= IDLE;
            r_con    <= 1'b0;
            r_taken  <= '0;
            r_ntaken <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == T3 && !bus.abort) r_con <= w_cond;
            if (w_inc_t && !(&r_taken)) r_taken <= r_taken + CNT_W'(1);
            if (w_inc_n && !(&r_ntaken)) r_ntaken <= r_ntaken + CNT_W'(1);
        end
    end
    assign bus.Gra        = (r_state == T3);
    assign bus.Rout       = (r_state == T3);
    assign bus.CONin      = (r_state == T3);
    assign bus.PCout      = (r_state == T4);
    assign bus.Yin        = (r_state == T4);
    assign bus.Cout       = (r_state == T5);
    assign bus.ADD        = (r_state == T5);
    assign bus.Zin        = (r_state == T5);
    assign bus.Zlowout    = (r_state == T6);
    assign bus.PCin       = (r_state == T6) && r_con && !bus.abort;
    assign bus.CON        = r_con;
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = w_done;
    assign bus.taken_cnt  = r_taken;
    assign bus.ntaken_cnt = r_ntaken;
endmodule

// File: tb/tb_branch_seq.sv
// tb_branch_seq: scoreboard bench; dut_a runs EARLY_EXIT=1/CNT_W=16, dut_b runs EARLY_EXIT=0/CNT_W=2.
module tb_branch_seq;
    typedef struct {
        int   len;
        logic pcin;
        logic con;
    } exp_t;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int   len_a = 0, len_b = 0;
    logic pc_a = 1'b0, pc_b = 1'b0;
    bit   chk_a = 0, chk_b = 0;
    logic ec_a = 1'b0, ec_b = 1'b0;
    branch_seq_if #(.CNT_W(16)) ifa ();
    branch_seq_if #(.CNT_W(2))  ifb ();
    branch_seq #(.EARLY_EXIT(1), .CNT_W(16)) dut_a (.clock(clk), .clear(clr), .bus(ifa));
    branch_seq #(.EARLY_EXIT(0), .CNT_W(2))  dut_b (.clock(clk), .clear(clr), .bus(ifb));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    // Pulses start for one cycle; returns one step into the T3 cycle.
    task automatic go(input bit on_b, input logic [1:0] code, input logic [31:0] bv,
                      input logic con, input bit push);
        exp_t e;
        e.con  = con;
        e.pcin = con;
        e.len  = (!on_b && !con) ? 1 : 4;
        settle(1);
        if (on_b) begin
            ifb.start = 1'b1; ifb.IR = {11'd0, code, 19'd0}; ifb.busContents = bv;
            if (push) qb.push_back(e);
        end else begin
            ifa.start = 1'b1; ifa.IR = {11'd0, code, 19'd0}; ifa.busContents = bv;
            if (push) qa.push_back(e);
        end
        settle(1);
        ifa.start = 1'b0;
        ifb.start = 1'b0;
    endtask
    always @(negedge clk) begin
        if (chk_a) begin check("con_a", ifa.CON, ec_a); chk_a = 0; end
        if (ifa.busy) len_a++;
        pc_a = pc_a | ifa.PCin;
        if (ifa.done) begin
            if (qa.size() == 0) check("extra_done_a", qa.size(), 1);
            else begin
                ea = qa.pop_front();
                check("len_a", len_a, ea.len);
                check("pcin_a", pc_a, ea.pcin);
                ec_a = ea.con; chk_a = 1;
            end
            len_a = 0; pc_a = 1'b0;
        end else if (!ifa.busy) begin
            len_a = 0; pc_a = 1'b0;
        end
    end
    always @(negedge clk) begin
        if (chk_b) begin check("con_b", ifb.CON, ec_b); chk_b = 0; end
        if (ifb.busy) len_b++;
        pc_b = pc_b | ifb.PCin;
        if (ifb.done) begin
            if (qb.size() == 0) check("extra_done_b", qb.size(), 1);
            else begin
                eb = qb.pop_front();
                check("len_b", len_b, eb.len);
                check("pcin_b", pc_b, eb.pcin);
                ec_b = eb.con; chk_b = 1;
            end
            len_b = 0; pc_b = 1'b0;
        end else if (!ifb.busy) begin
            len_b = 0; pc_b = 1'b0;
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
        $fatal(1, "timeout");
    end
    initial begin
        ifa.start = 1'b0; ifa.abort = 1'b0; ifa.IR = '0; ifa.busContents = '0;
        ifb.start = 1'b0; ifb.abort = 1'b0; ifb.IR = '0; ifb.busContents = '0;
        settle(3);
        clr = 1'b0;
        check("rst_busy_a", ifa.busy, 0);
        check("rst_done_a", ifa.done, 0);
        check("rst_con_a", ifa.CON, 0);
        check("rst_gra_a", ifa.Gra, 0);
        check("rst_taken_a", ifa.taken_cnt, 0);
        check("rst_ntaken_a", ifa.ntaken_cnt, 0);
        check("rst_busy_b", ifb.busy, 0);
        check("rst_pcin_b", ifb.PCin, 0);
        check("rst_taken_b", ifb.taken_cnt, 0);
        // brzr taken
        go(0, 2'b00, 32'd0, 1'b1, 1);
        settle(4);
        check("brzr_taken_cnt", ifa.taken_cnt, 1);
        // brnz not taken, early exit
        go(0, 2'b01, 32'd0, 1'b0, 1);
        settle(1);
        check("brnz_ntaken_cnt", ifa.ntaken_cnt, 1);
        check("brnz_busy", ifa.busy, 0);
        go(0, 2'b11, 32'h8000_0000, 1'b1, 1);
        settle(4);
        go(0, 2'b10, 32'd0, 1'b0, 1);
        settle(1);
        check("a_cnts", {ifa.taken_cnt, ifa.ntaken_cnt}, {16'd2, 16'd2});
        // back-to-back with a stray start during T4
        go(0, 2'b00, 32'd0, 1'b1, 1);
        settle(1);
        ifa.start = 1'b1;
        settle(1);
        ifa.start = 1'b0;
        settle(1);
        go(0, 2'b00, 32'd0, 1'b1, 1);
        @(negedge clk);
        check("b2b_t3", ifa.Gra, 1);
        settle(4);
        check("b2b_taken_cnt", ifa.taken_cnt, 4);
        // signed cases, full sequences
        go(1, 2'b10, 32'h8000_0000, 1'b0, 1);
        settle(4);
        check("pos_neg_ntaken", ifb.ntaken_cnt, 1);
        go(1, 2'b11, 32'h8000_0000, 1'b1, 1);
        settle(4);
        go(1, 2'b10, 32'h0000_0001, 1'b1, 1);
        settle(4);
        check("signed_taken", ifb.taken_cnt, 2);
        // abort in T5
        go(1, 2'b00, 32'd5, 1'b0, 0);
        settle(2);
        ifb.abort = 1'b1;
        @(negedge clk);
        check("abort_zin", ifb.Zin, 1);
        check("abort_done", ifb.done, 0);
        settle(1);
        ifb.abort = 1'b0;
        check("abort_idle", ifb.busy, 0);
        check("abort_pcin", ifb.PCin, 0);
        check("abort_cnts", {ifb.taken_cnt, ifb.ntaken_cnt}, {2'd2, 2'd1});
        go(1, 2'b01, 32'd5, 1'b1, 1);
        settle(4);
        check("post_abort_taken", ifb.taken_cnt, 3);
        // saturation
        go(1, 2'b11, 32'hFFFF_FFFF, 1'b1, 1);
        settle(4);
        go(1, 2'b11, 32'hFFFF_FFFF, 1'b1, 1);
        settle(4);
        check("sat_taken", ifb.taken_cnt, 3);
        check("sat_ntaken", ifb.ntaken_cnt, 1);
        // clear mid-T4
        go(1, 2'b00, 32'd0, 1'b1, 0);
        settle(1);
        clr = 1'b1;
        settle(1);
        clr = 1'b0;
        check("clr_busy", ifb.busy, 0);
        check("clr_strobes", {ifb.PCout, ifb.Yin, ifb.Cout, ifb.Zin, ifb.done}, 0);
        check("clr_con", ifb.CON, 0);
        check("clr_cnts", {ifb.taken_cnt, ifb.ntaken_cnt}, 0);
        settle(2);
        check("q_empty", qa.size() + qb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
